// File: rtl/dct_frame_loader.sv
// Serial-to-parallel frame loader for the 16-point DCT: frame_valid 1 cycle after the closing sample.
// One frame can be held behind a stalled output slot; s_ready drops only while that held frame waits.
module dct_frame_loader #(
   parameter int N = 16,
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [W-1:0]   s_data,
   input  logic           s_last,
   output logic [N*W-1:0] xout,
   output logic           frame_valid,
   input  logic           frame_ready,
   output logic           err_short,
   output logic           err_nolast
);

   localparam int IW = $clog2(N);

   typedef enum logic {
      FILLING = 1'b0,
      FULL    = 1'b1
   } fill_state_t;

   fill_state_t    state, state_nxt;
   logic [W-1:0]   mem [N];
   logic [IW-1:0]  wr_idx;
   logic [N*W-1:0] held;
   logic [N*W-1:0] frame;
   logic           accept;
   logic           last_slot;
   logic           close;
   logic           slot_free;

   assign s_ready   = (state == FILLING);
   assign accept    = s_valid && s_ready;
   assign last_slot = (wr_idx == IW'(N - 1));
   assign close     = accept && (last_slot || s_last);
   assign slot_free = !frame_valid || frame_ready;

   // Closing frame: stored samples, the sample accepted this cycle, zeros beyond it.
   always_comb begin
      frame = '0;
      for (int i = 0; i < N; i++) begin
         if (IW'(i) < wr_idx)
            frame[i*W +: W] = mem[i];
         else if (IW'(i) == wr_idx)
            frame[i*W +: W] = s_data;
         else
            frame[i*W +: W] = '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILLING: if (close && !slot_free) state_nxt = FULL;
         FULL:    if (frame_ready)         state_nxt = FILLING;
         default: state_nxt = FILLING;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= FILLING;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx      <= '0;
         held        <= '0;
         xout        <= '0;
         frame_valid <= 1'b0;
         err_short   <= 1'b0;
         err_nolast  <= 1'b0;
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else begin
         err_short  <= close && !last_slot;
         err_nolast <= close && last_slot && !s_last;

         if (accept) begin
            mem[wr_idx] <= s_data;
            wr_idx      <= close ? '0 : wr_idx + 1'b1;
         end

         if (state == FULL) begin
            // frame_valid stays high: the held frame replaces the consumed one.
            if (frame_ready) xout <= held;
         end else if (close) begin
            if (slot_free) begin
               xout        <= frame;
               frame_valid <= 1'b1;
            end else begin
               held <= frame;
            end
         end else if (frame_ready) begin
            frame_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/dct_frame_loader.md
DCT_FRAME_LOADER -- requirements
Module: dct_frame_loader

Interface
REQ-001 Parameter N, default 16: samples per frame; only N=16 is required.
REQ-002 Parameter W, default 16: sample width, signed Q1.15.
REQ-003 clk  in  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 s_valid  in  1: input sample valid.
REQ-006 s_ready  out  1: loader can accept a sample.
REQ-007 s_data  in  W: signed sample.
REQ-008 s_last  in  1: marks the final sample of a frame; qualified by s_valid.
REQ-009 xout  out  N*W: parallel frame; sample n is xout[16n+15:16n]; feeds the 16-input DCT stage.
REQ-010 frame_valid  out  1: xout holds a complete frame.
REQ-011 frame_ready  in  1: consumer takes the frame.
REQ-012 err_short  out  1: one-cycle pulse on a frame closed early by s_last.
REQ-013 err_nolast  out  1: one-cycle pulse on a frame closed at 16 samples without s_last.

Function
REQ-014 A sample is accepted when s_valid and s_ready are both high in the same cycle; accepted samples are written to the fill buffer at index wr_idx (0..15), then wr_idx increments.
REQ-015 A frame closes on the cycle that accepts the sample at wr_idx=15, or any accepted sample with s_last=1; wr_idx returns to 0 on the next cycle.
REQ-016 On close, entries with index >= (number of accepted samples) SHALL be zero in the emitted frame; earlier samples are bit-exact, in arrival order.
REQ-017 err_short pulses in the cycle after a close with fewer than 16 samples; err_nolast pulses in the cycle after a 16-sample close with s_last=0; both are otherwise 0.
REQ-018 Output slot states: EMPTY (frame_valid=0) and VALID (frame_valid=1).
REQ-019 VALID -> EMPTY when frame_ready=1; the handshake takes exactly one cycle; xout and frame_valid are stable while VALID and frame_ready=0.
REQ-020 Fill buffer states: FILLING and FULL.
REQ-021 On close, if the slot is EMPTY or is being consumed in that same cycle, the frame moves to xout with frame_valid=1 from the next cycle, and the fill buffer stays FILLING.
REQ-022 Latency: last accepted sample at cycle t -> frame_valid=1 at t+1.
REQ-023 If the slot is VALID and not being consumed on close, the fill buffer enters FULL; s_ready=0 while FULL.
REQ-024 FULL -> FILLING on the cycle frame_ready=1; the held frame moves to xout at the next cycle and frame_valid stays high, giving back-to-back frames.
REQ-025 s_ready=1 in FILLING, including the cycle after a close, so samples stream at 1/cycle with no bubble when the consumer keeps up.
REQ-026 s_ready is a registered state decode with no combinational path from s_valid; it MAY depend combinationally on frame_ready only via the FULL state.
REQ-027 When frame_valid=0, xout keeps its last value; the DCT stage latches xout only when frame_valid=1.
REQ-028 Simultaneous close and frame_ready while FULL cannot occur because s_ready=0 in FULL; s_valid while s_ready=0 is ignored with no state change.

Reset
REQ-029 With rst_n=0: wr_idx=0, fill buffer FILLING, slot EMPTY, frame_valid=0, err_short=0, err_nolast=0, xout=0, s_ready=1 (the first edge after release can accept).
REQ-030 Reset mid-frame discards partial and held frames, with no error pulse.

Verification
REQ-031 16 samples 0x0001..0x0010 on consecutive cycles, s_last on the 16th, frame_ready=1 -> frame_valid at the cycle after the 16th sample, xout[15:0]=0x0001, xout[255:240]=0x0010, no error pulses.
REQ-032 5 samples 0x8000,0x7FFF,0x0001,0xFFFF,0x1234 with s_last on the 5th -> samples 0..4 exact, samples 5..15=0, err_short pulses for 1 cycle.
REQ-033 16 samples without s_last -> frame emitted and err_nolast pulses once; the next sample goes to index 0.
REQ-034 frame_ready=0 while 2 frames of 16 are streamed -> first frame is held stable, s_ready drops after the second close; raising frame_ready for 1 cycle gives the second frame the next cycle and s_ready=1.
REQ-035 Continuous stream of 4 frames with frame_ready=1 -> s_ready never deasserts, 4 frame_valid pulses spaced 16 cycles apart.
REQ-036 rst_n low for 1 cycle after 7 samples, then 16 new samples -> the frame contains only the new samples, no err_short.
